// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU/loader memory arbitration slice.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    localparam int REQ_CPU    = 0;
    localparam int REQ_DMA    = 1;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational 2-way round-robin pick; last is the index of the previous grant.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // On a tie the requester that did not win last time takes the grant.
    always_comb begin
        grant    = '0;
        grant[0] = req[0] & (~req[1] | last);
        grant[1] = req[1] & (~req[0] | ~last);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: round-robin grant, fixed-latency access, one-cycle ack.
module mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_LAT = 1
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [1:0]          Req,
    input  logic [1:0]          Wr,
    input  logic [2*ADDR_W-1:0] Addr,
    input  logic [2*DATA_W-1:0] WData,
    output logic [1:0]          Ack,
    output logic [DATA_W-1:0]   RData,
    output logic                Mem_Read,
    output logic                Mem_Write,
    output logic [ADDR_W-1:0]   Mem_Addr,
    output logic [DATA_W-1:0]   Mem_WData,
    input  logic [DATA_W-1:0]   Mem_RData,
    output logic [1:0]          Owner
);

    localparam logic [3:0] LAT_CNT = 4'(MEM_LAT);

    arb_state_t          r_state;
    logic [3:0]          r_cnt;
    logic                r_last;
    logic                r_wr;
    logic [1:0]          r_owner;
    logic [1:0]          r_ack;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_mem_rd;
    logic                r_mem_wr;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic [1:0]          w_grant;
    logic                w_sel_dma;
    logic                w_wr_sel;
    logic [ADDR_W-1:0]   w_addr_sel;
    logic [DATA_W-1:0]   w_wdata_sel;

    rr_arbiter2 u_rr (
        .req   (Req),
        .last  (r_last),
        .grant (w_grant)
    );

    always_comb begin
        w_sel_dma   = w_grant[REQ_DMA];
        w_wr_sel    = w_sel_dma ? Wr[REQ_DMA] : Wr[REQ_CPU];
        w_addr_sel  = w_sel_dma ? Addr[REQ_DMA*ADDR_W +: ADDR_W]
                                : Addr[REQ_CPU*ADDR_W +: ADDR_W];
        w_wdata_sel = w_sel_dma ? WData[REQ_DMA*DATA_W +: DATA_W]
                                : WData[REQ_CPU*DATA_W +: DATA_W];
    end

    // Memory strobes are registered on grant so they are valid for every ACCESS cycle.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_last      <= 1'b1;
            r_wr        <= 1'b0;
            r_owner     <= '0;
            r_ack       <= '0;
            r_rdata     <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|Req) begin
                        r_owner     <= w_grant;
                        r_wr        <= w_wr_sel;
                        r_mem_rd    <= ~w_wr_sel;
                        r_mem_wr    <= w_wr_sel;
                        r_mem_addr  <= w_addr_sel;
                        r_mem_wdata <= w_wdata_sel;
                        r_cnt       <= LAT_CNT;
                        r_state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_cnt == 4'd1) begin
                        r_mem_rd    <= 1'b0;
                        r_mem_wr    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        r_ack       <= r_owner;
                        r_rdata     <= r_wr ? '0 : Mem_RData;
                        r_cnt       <= '0;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_ack   <= '0;
                    r_rdata <= '0;
                    r_last  <= r_owner[REQ_DMA];
                    r_owner <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Ack       = r_ack;
    assign RData     = r_rdata;
    assign Owner     = r_owner;
    assign Mem_Read  = r_mem_rd;
    assign Mem_Write = r_mem_wr;
    assign Mem_Addr  = r_mem_addr;
    assign Mem_WData = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with MEM_LAT=2 and a combinational memory model.
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic                Clk = 1'b0;
    logic                Rst;
    logic [1:0]          Req;
    logic [1:0]          Wr;
    logic [2*AW-1:0]     Addr;
    logic [2*DW-1:0]     WData;
    logic [1:0]          Ack;
    logic [DW-1:0]       RData;
    logic                Mem_Read;
    logic                Mem_Write;
    logic [AW-1:0]       Mem_Addr;
    logic [DW-1:0]       Mem_WData;
    logic [DW-1:0]       Mem_RData;
    logic [1:0]          Owner;

    int n_vec = 0;
    int n_err = 0;

    mem_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .MEM_LAT (LAT)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Req       (Req),
        .Wr        (Wr),
        .Addr      (Addr),
        .WData     (WData),
        .Ack       (Ack),
        .RData     (RData),
        .Mem_Read  (Mem_Read),
        .Mem_Write (Mem_Write),
        .Mem_Addr  (Mem_Addr),
        .Mem_WData (Mem_WData),
        .Mem_RData (Mem_RData),
        .Owner     (Owner)
    );

    always #5 Clk = ~Clk;

    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_0000);
    endfunction

    assign Mem_RData = mem_model(Mem_Addr);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_owner"}, Owner, 0);
        chk({tag, "_ack"}, Ack, 0);
        chk({tag, "_rdata"}, RData, 0);
        chk({tag, "_mrd"}, Mem_Read, 0);
        chk({tag, "_mwr"}, Mem_Write, 0);
        chk({tag, "_maddr"}, Mem_Addr, 0);
        chk({tag, "_mwdata"}, Mem_WData, 0);
    endtask

    // Inputs already driven; walks grant, LAT access cycles, response and idle.
    task automatic txn(input string tag, input logic [1:0] own, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [DW-1:0] rd, input bit drop);
        step();
        for (int c = 0; c < LAT; c++) begin
            chk({tag, "_owner"}, Owner, own);
            chk({tag, "_mrd"}, Mem_Read, !wr);
            chk({tag, "_mwr"}, Mem_Write, wr);
            chk({tag, "_excl"}, Mem_Read & Mem_Write, 0);
            chk({tag, "_maddr"}, Mem_Addr, a);
            chk({tag, "_mwdata"}, Mem_WData, wd);
            chk({tag, "_ack_early"}, Ack, 0);
            step();
        end
        chk({tag, "_ack"}, Ack, own);
        chk({tag, "_rdata"}, RData, rd);
        chk({tag, "_owner_resp"}, Owner, own);
        chk({tag, "_mrd_off"}, Mem_Read, 0);
        chk({tag, "_mwr_off"}, Mem_Write, 0);
        if (drop) Req = '0;
        step();
        chk({tag, "_ack_off"}, Ack, 0);
        chk({tag, "_rdata_off"}, RData, 0);
        chk({tag, "_owner_idle"}, Owner, 0);
    endtask

    initial begin
        Rst = 1'b0; Req = '0; Wr = '0; Addr = '0; WData = '0;
        step();
        step();
        reset_chk("por");
        Rst = 1'b1;

        // Single CPU read of 0x10
        Addr[AW-1:0] = 32'h10;
        Req = 2'b01;
        txn("rd0", 2'b01, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b1);
        step();
        chk("rd0_no_regrant", Owner, 0);

        // Fresh reset, then simultaneous writes held for four grants
        Rst = 1'b0;
        step();
        Rst = 1'b1;
        Req = 2'b11; Wr = 2'b11;
        Addr  = {32'h200, 32'h100};
        WData = {32'h2222, 32'h1111};
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0)
                txn("wr_cpu", 2'b01, 1'b1, 32'h100, 32'h1111, 32'h0, k == 3);
            else
                txn("wr_dma", 2'b10, 1'b1, 32'h200, 32'h2222, 32'h0, k == 3);
        end

        // CPU read leaves last-grant = CPU; DMA read then aborted by reset
        Wr = '0; WData = '0;
        Addr = {32'h20, 32'h10};
        Req = 2'b01;
        txn("rd1", 2'b01, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b1);
        Req = 2'b10;
        step();
        chk("abort_owner", Owner, 2'b10);
        chk("abort_mrd", Mem_Read, 1);
        #2 Rst = 1'b0;
        #1 reset_chk("rst_async");
        step();
        reset_chk("rst_hold");
        Rst = 1'b1;
        Addr = {32'h20, 32'h30};
        Req = 2'b11;
        txn("post_rst", 2'b01, 1'b0, 32'h30, 32'h0, 32'hC0DE_0030, 1'b1);

        // DMA read with Req withdrawn during ACCESS
        Req = 2'b10;
        step();
        chk("wd_owner", Owner, 2'b10);
        Req = '0;
        step();
        chk("wd_owner2", Owner, 2'b10);
        chk("wd_mrd", Mem_Read, 1);
        chk("wd_maddr", Mem_Addr, 32'h20);
        step();
        chk("wd_ack", Ack, 2'b10);
        chk("wd_rdata", RData, 32'hC0DE_0020);
        step();
        chk("wd_ack_off", Ack, 0);
        chk("wd_owner_idle", Owner, 0);
        step();
        chk("wd_stay_idle", Owner, 0);
        chk("wd_stay_mrd", Mem_Read, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
